// File: rtl/bus_fabric.sv
// Single-master address decoder and access sequencer: routes one request to one of N_SLV
// windows, waits for that slave's ready (bounded by TIMEOUT) and returns registered data/error.
module bus_fabric #(
    parameter int                        N_SLV    = 4,
    parameter int                        ADDR_W   = 8,
    parameter int                        DATA_W   = 8,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {8'h90, 8'h84, 8'h80, 8'h00},
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_LAST = {8'h93, 8'h87, 8'h83, 8'h7F},
    parameter int                        TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_wr_en,
    input  logic                      m_rd_en,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [N_SLV-1:0]          s_wr_en,
    output logic [N_SLV-1:0]          s_rd_en,
    input  logic [N_SLV*DATA_W-1:0]   s_rdata,
    input  logic [N_SLV-1:0]          s_ready,
    output logic [7:0]                err_cnt,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [1:0]                dbg_state
);
    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_is_wr;
    logic [7:0]          r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [N_SLV-1:0]    r_wr_en;
    logic [N_SLV-1:0]    r_rd_en;
    logic [7:0]          r_err_cnt;
    logic [ADDR_W-1:0]   r_err_addr;

    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic [N_SLV-1:0]    w_hot;
    logic                w_sel_ready;
    logic [DATA_W-1:0]   w_sel_rdata;

    // Scan from the top index down so the lowest matching window is the last one written.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        w_hot = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (m_addr >= SLV_BASE[i*ADDR_W +: ADDR_W] && m_addr <= SLV_LAST[i*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_sel = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_SLV; i++) begin
            w_hot[i] = w_hit && (w_sel == SEL_W'(i));
        end
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ready = s_ready[i];
                w_sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_is_wr    <= 1'b0;
            r_cnt      <= 8'd0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr_en    <= '0;
            r_rd_en    <= '0;
            r_err_cnt  <= 8'd0;
            r_err_addr <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (m_wr_en || m_rd_en) begin
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_cnt   <= 8'd0;
                        if ((m_wr_en && m_rd_en) || !w_hit) begin
                            r_state    <= ST_RESP;
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_rdata    <= '0;
                            r_err_addr <= m_addr;
                            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_sel   <= w_sel;
                            r_is_wr <= m_wr_en;
                            r_wr_en <= m_wr_en ? w_hot : '0;
                            r_rd_en <= m_rd_en ? w_hot : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // A ready arriving in the final allowed cycle still completes cleanly.
                    if (w_sel_ready) begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= r_is_wr ? '0 : w_sel_rdata;
                        r_wr_en <= '0;
                        r_rd_en <= '0;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state    <= ST_RESP;
                        r_ready    <= 1'b1;
                        r_err      <= 1'b1;
                        r_rdata    <= '0;
                        r_wr_en    <= '0;
                        r_rd_en    <= '0;
                        r_err_addr <= r_addr;
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_rdata   = r_rdata;
    assign m_ready   = r_ready;
    assign m_err     = r_err;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign s_wr_en   = r_wr_en;
    assign s_rd_en   = r_rd_en;
    assign err_cnt   = r_err_cnt;
    assign err_addr  = r_err_addr;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: latency-programmable slave models plus a transaction-level reference
// model of decode, wait states, timeout and the saturating error log.
module tb_bus_fabric;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_wdata = 8'h00;
    logic        m_wr_en = 1'b0;
    logic        m_rd_en = 1'b0;
    logic [7:0]  m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [7:0]  s_addr;
    logic [7:0]  s_wdata;
    logic [3:0]  s_wr_en;
    logic [3:0]  s_rd_en;
    logic [31:0] s_rdata;
    logic [3:0]  s_ready = 4'b0000;
    logic [7:0]  err_cnt;
    logic [7:0]  err_addr;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    // Slave models: channel i raises ready after lat[i] strobed cycles.
    int          lat[4] = '{0, 0, 0, 0};
    int          scnt[4] = '{0, 0, 0, 0};
    logic [7:0]  sdata[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic        noise = 1'b0;
    logic [7:0]  win_base[4] = '{8'h00, 8'h80, 8'h84, 8'h90};
    logic [7:0]  win_last[4] = '{8'h7F, 8'h83, 8'h87, 8'h93};

    // Reference model state and per-access expectations.
    int          mc = 0;
    logic [7:0]  ma = 8'h00;
    logic        e_err;
    logic [3:0]  e_wr, e_rd;
    int          e_cycles, e_lat;
    logic [7:0]  e_rdata;

    // Observations of one access.
    int          ob_cycles, ob_lat;
    logic [7:0]  ob_rdata, ob_saddr, ob_swdata;
    logic        ob_err, ob_multi, ob_hung, ob_twice;
    logic [3:0]  ob_wr_or, ob_rd_or;

    assign s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

    bus_fabric dut (
        .clk(clk), .reset(reset),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_cnt(err_cnt), .err_addr(err_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s_wr_en[i] || s_rd_en[i]) begin
                s_ready[i] = (scnt[i] >= lat[i]);
                scnt[i]++;
            end else begin
                scnt[i] = 0;
                s_ready[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic void model_access(input logic [7:0] a, input logic wr, input logic rd);
        int ch;
        int k;
        logic [3:0] hot;
        ch = -1;
        for (int i = 0; i < 4; i++)
            if (ch < 0 && a >= win_base[i] && a <= win_last[i]) ch = i;
        e_wr = 4'b0; e_rd = 4'b0; e_rdata = 8'h00; e_err = 1'b0; e_cycles = 0; e_lat = 1;
        if ((wr && rd) || ch < 0) begin
            e_err = 1'b1;
        end else begin
            k = lat[ch] + 1;
            if (k > TO) begin
                k = TO;
                e_err = 1'b1;
            end
            hot = 4'b0001 << ch;
            if (wr) e_wr = hot; else e_rd = hot;
            if (rd && !e_err) e_rdata = sdata[ch];
            e_cycles = k;
            e_lat = k + 1;
        end
        if (e_err) begin
            if (mc < 255) mc++;
            ma = a;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_access(input logic [7:0] a, input logic [7:0] wd, input logic wr, input logic rd);
        ob_cycles = 0; ob_lat = 0; ob_wr_or = 4'b0; ob_rd_or = 4'b0;
        ob_multi = 1'b0; ob_hung = 1'b1; ob_twice = 1'b0;
        ob_rdata = 8'hxx; ob_err = 1'bx;
        m_addr = a; m_wdata = wd; m_wr_en = wr; m_rd_en = rd;
        @(posedge clk);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            ob_lat++;
            if (n == 0) begin
                ob_saddr = s_addr;
                ob_swdata = s_wdata;
                m_addr = ~a;
            end
            if (s_wr_en != 4'b0 || s_rd_en != 4'b0) ob_cycles++;
            ob_wr_or |= s_wr_en;
            ob_rd_or |= s_rd_en;
            if ($countones({s_wr_en, s_rd_en}) > 1) ob_multi = 1'b1;
            if (m_ready) begin
                ob_rdata = m_rdata;
                ob_err = m_err;
                ob_hung = 1'b0;
                break;
            end
        end
        m_wr_en = 1'b0; m_rd_en = 1'b0;
        @(negedge clk);
        ob_twice = m_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({m_rdata, m_ready, m_err, s_addr, s_wdata, s_wr_en, s_rd_en, err_cnt, err_addr, dbg_state} !== 53'd0) begin
            bad++;
            $display("FAIL reset_values: rdata=%h rdy=%b err=%b saddr=%h swd=%h wr=%b rd=%b cnt=%h eaddr=%h st=%0d, all required 0",
                     m_rdata, m_ready, m_err, s_addr, s_wdata, s_wr_en, s_rd_en, err_cnt, err_addr, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_read();
        lat[2] = 0; sdata[2] = 8'hA5;
        model_access(8'h85, 1'b0, 1'b1);
        run_access(8'h85, 8'h00, 1'b0, 1'b1);
        total++;
        if (ob_hung || ob_lat !== e_lat) begin
            bad++; $display("FAIL zw_read_latency: got %0d required %0d", ob_lat, e_lat);
        end
        total++;
        if (ob_rd_or !== e_rd || ob_wr_or !== 4'b0 || ob_cycles !== e_cycles) begin
            bad++; $display("FAIL zw_read_strobe: rd=%b wr=%b cyc=%0d required rd=%b cyc=%0d", ob_rd_or, ob_wr_or, ob_cycles, e_rd, e_cycles);
        end
        total++;
        if (ob_rdata !== e_rdata || ob_err !== e_err || ob_twice !== 1'b0) begin
            bad++; $display("FAIL zw_read_resp: rdata=%h err=%b twice=%b required rdata=%h err=%b", ob_rdata, ob_err, ob_twice, e_rdata, e_err);
        end
    endtask

    task automatic test_wait_write();
        lat[3] = 5;
        model_access(8'h91, 1'b1, 1'b0);
        run_access(8'h91, 8'h3C, 1'b1, 1'b0);
        total++;
        if (ob_wr_or !== e_wr || ob_rd_or !== 4'b0 || ob_cycles !== e_cycles) begin
            bad++; $display("FAIL wait_write_strobe: wr=%b cyc=%0d required wr=%b cyc=%0d", ob_wr_or, ob_cycles, e_wr, e_cycles);
        end
        total++;
        if (ob_swdata !== 8'h3C || ob_saddr !== 8'h91) begin
            bad++; $display("FAIL wait_write_bus: saddr=%h swdata=%h required 91 3c", ob_saddr, ob_swdata);
        end
        total++;
        if (ob_hung || ob_err !== e_err || ob_lat !== e_lat) begin
            bad++; $display("FAIL wait_write_resp: err=%b lat=%0d required err=%b lat=%0d", ob_err, ob_lat, e_err, e_lat);
        end
    endtask

    task automatic test_unmapped();
        model_access(8'hA0, 1'b0, 1'b1);
        run_access(8'hA0, 8'h00, 1'b0, 1'b1);
        total++;
        if (ob_hung || ob_err !== 1'b1 || ob_lat !== e_lat || ob_cycles !== 0) begin
            bad++; $display("FAIL unmapped_resp: err=%b lat=%0d cyc=%0d required err=1 lat=%0d cyc=0", ob_err, ob_lat, ob_cycles, e_lat);
        end
        total++;
        if (err_addr !== ma || err_cnt !== 8'(mc)) begin
            bad++; $display("FAIL unmapped_log: eaddr=%h cnt=%0d required eaddr=%h cnt=%0d", err_addr, err_cnt, ma, mc);
        end
    endtask

    task automatic test_timeout();
        lat[0] = 99; sdata[0] = 8'h5A;
        model_access(8'h10, 1'b0, 1'b1);
        run_access(8'h10, 8'h00, 1'b0, 1'b1);
        total++;
        if (ob_hung || ob_cycles !== e_cycles || ob_err !== 1'b1 || ob_rdata !== 8'h00) begin
            bad++; $display("FAIL timeout_abort: cyc=%0d err=%b rdata=%h required cyc=%0d err=1 rdata=00", ob_cycles, ob_err, ob_rdata, e_cycles);
        end
        total++;
        if (err_addr !== ma || err_cnt !== 8'(mc)) begin
            bad++; $display("FAIL timeout_log: eaddr=%h cnt=%0d required eaddr=%h cnt=%0d", err_addr, err_cnt, ma, mc);
        end
        lat[0] = TO - 1;
        model_access(8'h10, 1'b0, 1'b1);
        run_access(8'h10, 8'h00, 1'b0, 1'b1);
        total++;
        if (ob_hung || ob_cycles !== e_cycles || ob_err !== e_err || ob_rdata !== e_rdata) begin
            bad++; $display("FAIL timeout_last_cycle_ready: cyc=%0d err=%b rdata=%h required cyc=%0d err=%b rdata=%h",
                            ob_cycles, ob_err, ob_rdata, e_cycles, e_err, e_rdata);
        end
    endtask

    task automatic test_protocol();
        model_access(8'h82, 1'b1, 1'b1);
        run_access(8'h82, 8'h11, 1'b1, 1'b1);
        total++;
        if (ob_hung || ob_err !== 1'b1 || ob_wr_or !== 4'b0 || ob_rd_or !== 4'b0 || ob_lat !== e_lat) begin
            bad++; $display("FAIL protocol_error: err=%b wr=%b rd=%b lat=%0d required err=1 no strobe lat=%0d", ob_err, ob_wr_or, ob_rd_or, ob_lat, e_lat);
        end
        total++;
        if (err_addr !== ma || err_cnt !== 8'(mc)) begin
            bad++; $display("FAIL protocol_log: eaddr=%h cnt=%0d required eaddr=%h cnt=%0d", err_addr, err_cnt, ma, mc);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, wd;
        logic wr, rd;
        int c, pick, kind;
        noise = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                lat[i] = $urandom_range(0, 20);
                sdata[i] = 8'($urandom);
            end
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                a = 8'($urandom_range(0, 255));
            end else begin
                c = $urandom_range(0, 3);
                a = win_base[c] + 8'($urandom_range(0, int'(win_last[c] - win_base[c])));
            end
            wd = 8'($urandom);
            kind = $urandom_range(0, 9);
            wr = (kind < 5);
            rd = (kind == 0) || (kind >= 5);
            model_access(a, wr, rd);
            run_access(a, wd, wr, rd);
            total++;
            if (ob_hung || ob_lat !== e_lat || ob_cycles !== e_cycles || ob_err !== e_err || ob_rdata !== e_rdata ||
                ob_wr_or !== e_wr || ob_rd_or !== e_rd || ob_multi || ob_twice || ob_saddr !== a) begin
                bad++;
                $display("FAIL random_access[%0d] a=%h wr=%b rd=%b: lat=%0d cyc=%0d err=%b rdata=%h wr=%b rd=%b multi=%b twice=%b saddr=%h required lat=%0d cyc=%0d err=%b rdata=%h wr=%b rd=%b",
                         t, a, wr, rd, ob_lat, ob_cycles, ob_err, ob_rdata, ob_wr_or, ob_rd_or, ob_multi, ob_twice, ob_saddr,
                         e_lat, e_cycles, e_err, e_rdata, e_wr, e_rd);
            end
            total++;
            if (err_addr !== ma || err_cnt !== 8'(mc)) begin
                bad++; $display("FAIL random_log[%0d]: eaddr=%h cnt=%0d required eaddr=%h cnt=%0d", t, err_addr, err_cnt, ma, mc);
            end
        end
        noise = 1'b0;
    endtask

    task automatic test_back_to_back_saturate();
        logic [7:0] a;
        logic wr;
        for (int t = 0; t < 260; t++) begin
            a = (t % 2 == 0) ? 8'(8'h94 + $urandom_range(0, 107)) : 8'(8'h88 + $urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            model_access(a, wr, !wr);
            run_access(a, 8'h00, wr, !wr);
            total++;
            if (ob_hung || ob_err !== 1'b1 || ob_lat !== 1) begin
                bad++; $display("FAIL b2b_err[%0d] a=%h: err=%b lat=%0d required err=1 lat=1", t, a, ob_err, ob_lat);
            end
        end
        total++;
        if (err_cnt !== 8'(mc) || err_addr !== ma) begin
            bad++; $display("FAIL err_cnt_saturate: cnt=%h eaddr=%h required cnt=%h eaddr=%h", err_cnt, err_addr, 8'(mc), ma);
        end
    endtask

    task automatic test_reset_mid_access();
        lat[1] = 0; sdata[1] = 8'hC3;
        model_access(8'h81, 1'b0, 1'b1);
        run_access(8'h81, 8'h00, 1'b0, 1'b1);
        lat[0] = 99;
        m_addr = 8'h20; m_rd_en = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (s_rd_en !== 4'b0001 || m_rdata !== 8'hC3 || err_cnt === 8'h00) begin
            bad++; $display("FAIL mid_access_setup: rd=%b rdata=%h cnt=%h required rd=0001 rdata=c3 cnt nonzero", s_rd_en, m_rdata, err_cnt);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (s_rd_en !== 4'b0 || s_wr_en !== 4'b0 || m_ready !== 1'b0 || err_cnt !== 8'h00 || m_rdata !== 8'h00 || err_addr !== 8'h00) begin
            bad++; $display("FAIL reset_mid_access: rd=%b wr=%b rdy=%b cnt=%h rdata=%h eaddr=%h required all 0",
                            s_rd_en, s_wr_en, m_ready, err_cnt, m_rdata, err_addr);
        end
        m_rd_en = 1'b0;
        mc = 0; ma = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lat[0] = 2; sdata[0] = 8'h7E;
        model_access(8'h20, 1'b0, 1'b1);
        run_access(8'h20, 8'h00, 1'b0, 1'b1);
        total++;
        if (ob_hung || ob_err !== e_err || ob_rdata !== e_rdata || ob_cycles !== e_cycles || err_cnt !== 8'(mc)) begin
            bad++; $display("FAIL post_reset_read: err=%b rdata=%h cyc=%0d cnt=%h required err=%b rdata=%h cyc=%0d cnt=%h",
                            ob_err, ob_rdata, ob_cycles, err_cnt, e_err, e_rdata, e_cycles, 8'(mc));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_unmapped();
        test_timeout();
        test_protocol();
        test_random();
        test_back_to_back_saturate();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
